// File: rtl/writeback_arbiter_l7_pkg.sv
// Shared widths and helpers for the writeback arbiter and its round-robin arbiter.
// The message struct lives in the top module because its widths are module parameters.
package writeback_arbiter_l7_pkg;

    localparam int PC_BITS        = 32;
    localparam int ARCH_ADDR_BITS = 5;
    localparam int DATA_BITS      = 32;

    // A one-input arbiter still needs a 1-bit pointer to have a legal vector.
    function automatic int ptr_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/writeback_arbiter_l7_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
// The pointer moves just past the winner whenever the grant is consumed.
module rr_arbiter
    import writeback_arbiter_l7_pkg::*;
#(
    parameter int p_width = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [p_width-1:0] req,
    input  logic               en,
    output logic [p_width-1:0] gnt
);

    localparam int PtrW = ptr_bits(p_width);

    logic [PtrW-1:0] ptr_q;
    logic [PtrW-1:0] ptr_d;
    logic            found;

    // First pass covers ptr..top; the second pass only wins when nothing at or above ptr requested.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < p_width; i++) begin
            if (!found && req[i] && (i >= int'(ptr_q))) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
        for (int i = 0; i < p_width; i++) begin
            if (!found && req[i]) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (en && (|gnt)) begin
            for (int i = 0; i < p_width; i++) begin
                if (gnt[i]) begin
                    ptr_d = (i == p_width - 1) ? '0 : PtrW'(i + 1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/writeback_arbiter_l7.sv
// Round-robin merge of execute-unit results into one registered writeback port.
// Data is passed through untouched; only the valid bit and arbitration pointer are reset.
module writeback_arbiter_l7
    import writeback_arbiter_l7_pkg::*;
#(
    parameter int p_num_pipes      = 4,
    parameter int p_seq_num_bits   = 5,
    parameter int p_phys_addr_bits = 6
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [p_num_pipes-1:0]                            ex_val,
    output logic [p_num_pipes-1:0]                            ex_rdy,
    input  logic [p_num_pipes-1:0][PC_BITS-1:0]               ex_pc,
    input  logic [p_num_pipes-1:0][p_seq_num_bits-1:0]        ex_seq_num,
    input  logic [p_num_pipes-1:0][ARCH_ADDR_BITS-1:0]        ex_waddr,
    input  logic [p_num_pipes-1:0][DATA_BITS-1:0]             ex_wdata,
    input  logic [p_num_pipes-1:0]                            ex_wen,
    input  logic [p_num_pipes-1:0][p_phys_addr_bits-1:0]      ex_preg,
    input  logic [p_num_pipes-1:0][p_phys_addr_bits-1:0]      ex_ppreg,
    output logic                                              w_val,
    input  logic                                              w_rdy,
    output logic [PC_BITS-1:0]                                w_pc,
    output logic [p_seq_num_bits-1:0]                         w_seq_num,
    output logic [ARCH_ADDR_BITS-1:0]                         w_waddr,
    output logic [DATA_BITS-1:0]                              w_wdata,
    output logic                                              w_wen,
    output logic [p_phys_addr_bits-1:0]                       w_preg,
    output logic [p_phys_addr_bits-1:0]                       w_ppreg
);

    typedef struct packed {
        logic [PC_BITS-1:0]          pc;
        logic [p_seq_num_bits-1:0]   seq_num;
        logic [ARCH_ADDR_BITS-1:0]   waddr;
        logic [DATA_BITS-1:0]        wdata;
        logic                        wen;
        logic [p_phys_addr_bits-1:0] preg;
        logic [p_phys_addr_bits-1:0] ppreg;
    } x_w_msg_t;

    logic [p_num_pipes-1:0] gnt;
    logic                   can_accept;
    logic                   accept;
    x_w_msg_t               sel_msg;
    x_w_msg_t               out_msg_q;
    x_w_msg_t               out_msg_d;
    logic                   out_val_q;
    logic                   out_val_d;

    rr_arbiter #(
        .p_width (p_num_pipes)
    ) u_rr_arbiter (
        .clk (clk),
        .rst (rst),
        .req (ex_val),
        .en  (can_accept),
        .gnt (gnt)
    );

    // A slot is free when empty or when the current occupant leaves this cycle.
    always_comb begin
        can_accept = !out_val_q || w_rdy;
        accept     = (|gnt) && can_accept && !rst;
        ex_rdy     = (can_accept && !rst) ? gnt : '0;
    end

    always_comb begin
        sel_msg = '0;
        for (int i = 0; i < p_num_pipes; i++) begin
            if (gnt[i]) begin
                sel_msg.pc      = ex_pc[i];
                sel_msg.seq_num = ex_seq_num[i];
                sel_msg.waddr   = ex_waddr[i];
                sel_msg.wdata   = ex_wdata[i];
                sel_msg.wen     = ex_wen[i];
                sel_msg.preg    = ex_preg[i];
                sel_msg.ppreg   = ex_ppreg[i];
            end
        end
    end

    always_comb begin
        out_val_d = out_val_q;
        out_msg_d = out_msg_q;
        if (accept) begin
            out_val_d = 1'b1;
            out_msg_d = sel_msg;
        end else if (out_val_q && w_rdy) begin
            out_val_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_val_q <= 1'b0;
        end else begin
            out_val_q <= out_val_d;
        end
        out_msg_q <= out_msg_d;
    end

    always_comb begin
        w_val     = out_val_q;
        w_pc      = out_msg_q.pc;
        w_seq_num = out_msg_q.seq_num;
        w_waddr   = out_msg_q.waddr;
        w_wdata   = out_msg_q.wdata;
        w_wen     = out_msg_q.wen;
        w_preg    = out_msg_q.preg;
        w_ppreg   = out_msg_q.ppreg;
    end

`ifndef SYNTHESIS
    function automatic string trace(input int trace_level);
        string s;
        s = "        ";
        if (accept) begin
            for (int i = 0; i < p_num_pipes; i++) begin
                if (gnt[i]) begin
                    s = $sformatf("g%0d:%02h  ", i, sel_msg.seq_num);
                end
            end
            if (trace_level > 1) begin
                s = {s, $sformatf("%08h ", sel_msg.wdata)};
            end
        end
        return s;
    endfunction
`endif

endmodule

// File: tb/tb_writeback_arbiter_l7.sv
// Self-checking bench for writeback_arbiter_l7: vector table, directed corner cases,
// and randomized traffic compared against a transaction-level reference model.
module tb_writeback_arbiter_l7;

    localparam int N = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  seq_num;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        wen;
        logic [5:0]  preg;
        logic [5:0]  ppreg;
    } msg_t;

    typedef struct {
        logic [N-1:0] val;
        logic         wrdy;
        logic         rst_in;
        logic [N-1:0] exp_rdy;
        logic         exp_wval;
    } vec_t;

    logic                clk;
    logic                rst;
    logic [N-1:0]        ex_val;
    logic [N-1:0]        ex_rdy;
    logic [N-1:0][31:0]  ex_pc;
    logic [N-1:0][4:0]   ex_seq_num;
    logic [N-1:0][4:0]   ex_waddr;
    logic [N-1:0][31:0]  ex_wdata;
    logic [N-1:0]        ex_wen;
    logic [N-1:0][5:0]   ex_preg;
    logic [N-1:0][5:0]   ex_ppreg;
    logic                w_val;
    logic                w_rdy;
    logic [31:0]         w_pc;
    logic [4:0]          w_seq_num;
    logic [4:0]          w_waddr;
    logic [31:0]         w_wdata;
    logic                w_wen;
    logic [5:0]          w_preg;
    logic [5:0]          w_ppreg;

    msg_t in_msg [N];

    int   n_checks;
    int   n_fail;

    int   model_ptr;
    bit   model_full;
    msg_t model_msg;

    vec_t tab [$];

    writeback_arbiter_l7 #(
        .p_num_pipes      (N),
        .p_seq_num_bits   (5),
        .p_phys_addr_bits (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_val     (ex_val),
        .ex_rdy     (ex_rdy),
        .ex_pc      (ex_pc),
        .ex_seq_num (ex_seq_num),
        .ex_waddr   (ex_waddr),
        .ex_wdata   (ex_wdata),
        .ex_wen     (ex_wen),
        .ex_preg    (ex_preg),
        .ex_ppreg   (ex_ppreg),
        .w_val      (w_val),
        .w_rdy      (w_rdy),
        .w_pc       (w_pc),
        .w_seq_num  (w_seq_num),
        .w_waddr    (w_waddr),
        .w_wdata    (w_wdata),
        .w_wen      (w_wen),
        .w_preg     (w_preg),
        .w_ppreg    (w_ppreg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Spread the per-input message records onto the packed DUT ports.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            ex_pc[i]      = in_msg[i].pc;
            ex_seq_num[i] = in_msg[i].seq_num;
            ex_waddr[i]   = in_msg[i].waddr;
            ex_wdata[i]   = in_msg[i].wdata;
            ex_wen[i]     = in_msg[i].wen;
            ex_preg[i]    = in_msg[i].preg;
            ex_ppreg[i]   = in_msg[i].ppreg;
        end
    end

    // Reference: scan inputs circularly from the pointer using modulo arithmetic.
    function automatic int model_grant(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(model_ptr + k) % N]) return (model_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_rdy();
        int g;
        g = model_grant(ex_val);
        if (rst || g < 0 || (model_full && !w_rdy)) return '0;
        return N'(1) << g;
    endfunction

    task automatic model_step();
        int g;
        g = model_grant(ex_val);
        if (rst) begin
            model_full = 0;
            model_ptr  = 0;
        end else if (g >= 0 && (!model_full || w_rdy)) begin
            model_msg  = in_msg[g];
            model_full = 1;
            model_ptr  = (g + 1) % N;
        end else if (model_full && w_rdy) begin
            model_full = 0;
        end
    endtask

    task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic randomize_payload();
        for (int i = 0; i < N; i++) begin
            in_msg[i].pc      = $urandom;
            in_msg[i].seq_num = 5'($urandom);
            in_msg[i].waddr   = 5'($urandom);
            in_msg[i].wdata   = $urandom;
            in_msg[i].wen     = 1'($urandom);
            in_msg[i].preg    = 6'($urandom);
            in_msg[i].ppreg   = 6'($urandom);
        end
    endtask

    // Drive one cycle, check combinational and registered outputs mid-cycle, then advance the model.
    task automatic apply_stimulus(input logic [N-1:0] val, input logic wrdy, input logic rst_in,
                                  input bit use_tab, input logic [N-1:0] tab_rdy, input logic tab_wval,
                                  input string name);
        msg_t w_msg;
        ex_val = val;
        w_rdy  = wrdy;
        rst    = rst_in;
        @(negedge clk);
        check_output({name, ".rdy"}, 128'(ex_rdy), 128'(model_rdy()));
        check_output({name, ".wval"}, 128'(w_val), 128'(model_full));
        if (model_full) begin
            w_msg = '{w_pc, w_seq_num, w_waddr, w_wdata, w_wen, w_preg, w_ppreg};
            check_output({name, ".wmsg"}, 128'(w_msg), 128'(model_msg));
        end
        if (use_tab) begin
            check_output({name, ".tab_rdy"}, 128'(ex_rdy), 128'(tab_rdy));
            check_output({name, ".tab_wval"}, 128'(w_val), 128'(tab_wval));
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        model_ptr  = 0;
        model_full = 0;
        model_msg  = '0;
        ex_val     = '0;
        w_rdy      = 1'b0;
        rst        = 1'b1;
        randomize_payload();
        @(posedge clk);
        model_step();
        #1;

        apply_stimulus(4'b1111, 1'b1, 1'b1, 1, 4'b0000, 1'b0, "reset_state");

        //                val      wrdy  rst   exp_rdy  exp_wval
        tab.push_back('{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0});
        tab.push_back('{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b0});
        tab.push_back('{4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1});
        tab.push_back('{4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1});
        tab.push_back('{4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1});
        tab.push_back('{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1});
        tab.push_back('{4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1});
        tab.push_back('{4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1});
        tab.push_back('{4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1});
        tab.push_back('{4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1});
        tab.push_back('{4'b0010, 1'b0, 1'b0, 4'b0000, 1'b1});
        tab.push_back('{4'b0010, 1'b0, 1'b0, 4'b0000, 1'b1});
        tab.push_back('{4'b0010, 1'b1, 1'b0, 4'b0010, 1'b1});
        tab.push_back('{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1});
        tab.push_back('{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0});
        tab.push_back('{4'b1001, 1'b1, 1'b0, 4'b1000, 1'b0});
        tab.push_back('{4'b1001, 1'b1, 1'b0, 4'b0001, 1'b1});
        tab.push_back('{4'b1001, 1'b1, 1'b0, 4'b1000, 1'b1});
        tab.push_back('{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1});
        tab.push_back('{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0});

        for (int r = 0; r < tab.size(); r++) begin
            randomize_payload();
            apply_stimulus(tab[r].val, tab[r].wrdy, tab[r].rst_in, 1, tab[r].exp_rdy, tab[r].exp_wval,
                           $sformatf("tab%0d", r));
        end

        // Single result on input 2, then confirm the pointer sits at 3 by racing inputs 1 and 3.
        apply_stimulus(4'b0000, 1'b1, 1'b1, 1, 4'b0000, 1'b0, "seq_rst");
        randomize_payload();
        in_msg[2].seq_num = 5'd5;
        in_msg[2].wdata   = 32'hDEADBEEF;
        apply_stimulus(4'b0100, 1'b1, 1'b0, 1, 4'b0100, 1'b0, "single_ex2");
        check_output("single.wval", 128'(w_val), 128'(1));
        check_output("single.seq", 128'(w_seq_num), 128'(5));
        check_output("single.wdata", 128'(w_wdata), 128'(32'hDEADBEEF));
        apply_stimulus(4'b1010, 1'b1, 1'b0, 1, 4'b1000, 1'b1, "ptr_at_3");

        // A store passes through untouched.
        in_msg[1].wen   = 1'b0;
        in_msg[1].waddr = 5'd7;
        apply_stimulus(4'b0010, 1'b1, 1'b0, 1, 4'b0010, 1'b1, "store_ex1");
        check_output("store.wen", 128'(w_wen), 128'(0));
        check_output("store.waddr", 128'(w_waddr), 128'(7));

        // Reset while stalled: held message is dropped and the pointer returns to 0.
        apply_stimulus(4'b0100, 1'b0, 1'b0, 1, 4'b0000, 1'b1, "stall");
        apply_stimulus(4'b0100, 1'b0, 1'b1, 1, 4'b0000, 1'b1, "rst_mid");
        check_output("rst_mid.wval", 128'(w_val), 128'(0));
        apply_stimulus(4'b0110, 1'b1, 1'b0, 1, 4'b0010, 1'b0, "after_rst");

        for (int c = 0; c < 400; c++) begin
            randomize_payload();
            apply_stimulus(N'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0),
                           0, '0, 1'b0, $sformatf("rand%0d", c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter_l7.md
# writeback_arbiter_l7

Collects completed results from `p_num_pipes` execute units (ALU, multiplier, the L7 load/store unit, …), each presenting an X→W handshake, and forwards one result per cycle to the writeback stage through a single registered X→W port. Arbitration is round-robin, so no execute unit can be starved. The block sits between the execute units' X side and the writeback/commit stage. It adds exactly one pipeline register and sustains full throughput.

## Interface
Parameters:
- `p_num_pipes`, default 4: number of execute-unit inputs; legal range ≥1.
- `p_seq_num_bits`, default 5: width of the ROB sequence number.
- `p_phys_addr_bits`, default 6: width of the physical register index.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `Ex[p_num_pipes]`  `X__WIntf.W_intf` array: inputs from the execute units.
  - Per-entry fields, all inputs except `rdy`: `val` 1; `rdy` out 1; `pc` 32; `seq_num` `p_seq_num_bits`; `waddr` 5; `wdata` 32; `wen` 1; `preg` `p_phys_addr_bits`; `ppreg` `p_phys_addr_bits`.
- `W`  `X__WIntf.X_intf`: output to writeback. Same fields with directions reversed.

## Operation
- Output register `out_reg` holds one X→W message plus a valid bit. `W.val` = `out_reg.val`, and all `W` data fields come directly from `out_reg`.
- `can_accept` = `!out_reg.val | W.rdy`.
- Round-robin pointer `ptr`, width `$clog2(p_num_pipes)`, with a minimum of 1 bit.
- Grant selection:
  - `grant` is one-hot: the first `i` with `Ex[i].val`, scanning `ptr`, `ptr+1`, … `p_num_pipes-1`, 0, … `ptr-1`.
  - If no `Ex[i].val` is set, `grant` is 0.
- `Ex[i].rdy` = `grant[i] & can_accept`. At most one `Ex` rdy is high in any cycle. `rdy` is low for every non-granted input, even one that is valid.
- On accept (`|grant & can_accept`):
  - `out_reg` ← the granted message with `val=1`.
  - `ptr` ← granted index + 1, wrapping from `p_num_pipes-1` to 0.
- Else, if `W.val & W.rdy`: `out_reg.val` ← 0 and the data fields become don't-care.
- Else: `out_reg` holds and `ptr` holds.
- Messages with `wen=0` (stores) are forwarded unchanged. Writeback needs them for commit.
- Data fields are never modified; the block is a pure mux plus register.
- Producers must not make `val` depend on `rdy`. Consumers may make `rdy` depend on `val`.
- `p_num_pipes=1` degenerates to a one-entry pipeline register, and `ptr` stays 0.

## Timing
- Reset values:
  - `out_reg.val`=0, so `W.val`=0.
  - `ptr`=0.
  - Every `Ex[i].rdy`=0 in the reset cycle; rdy is forced low while `rst`.
  - `W` data fields are X.
- Latency: a message accepted in cycle t is presented on `W` in cycle t+1.
- Throughput: one message per cycle while `W.rdy` stays high. Drain and fill in the same cycle is required.
- Back-pressure: when `W.rdy`=0 and `out_reg` is full, all `Ex[i].rdy`=0 and `W` holds stable until taken.
- Boundary cases:
  - Granted index `p_num_pipes-1` makes `ptr` wrap to 0.
  - If all inputs are valid simultaneously, each is granted once in every `p_num_pipes` consecutive accepts.
  - A reset asserted mid-operation drops the held message. On the cycle after reset: `W.val`=0 and `ptr`=0.
- Arbitration, `rdy` and `can_accept` are combinational within the cycle. Only `out_reg` and `ptr` are registered.

## Structure
- `x_w_msg` packed struct (`pc`, `seq_num`, `waddr`, `wdata`, `wen`, `preg`, `ppreg`):
  - Goes in package `UArch`, parameterized by width via localparams.
  - Alternatively it may be a local typedef, because the widths are module parameters.
- Sub-module `rr_arbiter`:
  - Parameter `p_width`.
  - Inputs: `clk`, `rst`, `req[p_width]`, `en`.
  - Output: one-hot `gnt[p_width]`.
  - Holds the pointer internally and advances it when `en & |gnt`. It is reusable by dispatch.
- A `trace(trace_level)` function (`ifndef SYNTHESIS`) prints the granted index and `seq_num` on accept, and spaces otherwise.

## Test plan
- Reset, then `Ex[2]` valid with `seq_num=5`, `wdata=32'hDEADBEEF`, `W.rdy=1` -> `Ex[2].rdy=1` in cycle 0; `W.val=1`, `seq_num=5`, `wdata=DEADBEEF` in cycle 1; `ptr=3`.
- All 4 inputs held valid, `W.rdy=1` for 8 cycles -> grant order 0,1,2,3,0,1,2,3 and one W transfer per cycle.
- `out_reg` full, `W.rdy=0` for 3 cycles, `Ex[1]` valid -> all `Ex.rdy=0` and `W` fields stable. When `W.rdy` rises, the old message transfers and `Ex[1]` is captured the same cycle.
- Wrap: `ptr=3`, `Ex[3]` and `Ex[0]` valid -> `Ex[3]` granted, then `Ex[0]`; `ptr` goes 3→0→1.
- Store with `wen=0`, `waddr=7` on `Ex[1]` -> appears on `W` with `wen=0` and `waddr=7`, unchanged.
- `rst` asserted while `out_reg` is full and `W.rdy=0` -> next cycle `W.val=0`, `ptr=0`; no transfer occurs.
